datamem_responder: RTL and testbench
====================================

DATAMEM_RESPONDER -- requirements
Module: datamem_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, storage size in bytes; power of two, at least 8.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_wdata  input  64  store data, right-aligned.
REQ-010 SHALL have port req_size  input  4  transfer bytes; legal values 1, 2, 4, 8.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  initiator takes the response.
REQ-013 SHALL have port resp_rdata  output  64  load data, zero-extended; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  request was illegal and had no effect.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL assert req_ready only in IDLE.
REQ-017 SHALL accept a request on a rising edge where req_valid && req_ready, then move to WAIT.
REQ-018 SHALL load the latency counter with LATENCY-1 on acceptance.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the cycle after it reads 0.
REQ-020 SHALL therefore raise resp_valid exactly LATENCY cycles after the acceptance edge.
REQ-021 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready is sampled high.
REQ-022 SHALL return to IDLE on the edge where resp_ready is sampled high in RESP.
REQ-023 SHALL allow only one outstanding request; req_ready is low from acceptance until the response handshake completes.
REQ-024 SHALL ignore resp_ready outside RESP.
REQ-025 SHALL ignore req_* inputs outside IDLE.
REQ-026 SHALL flag a request illegal when req_size is not in {1, 2, 4, 8}.
REQ-027 SHALL flag a request illegal when req_addr mod req_size != 0 (misaligned).
REQ-028 SHALL flag a request illegal when req_addr + req_size > MEM_BYTES, computed without 64-bit wrap.
REQ-029 SHALL, for an illegal request, write nothing, set resp_err=1 and set resp_rdata=0, with the same latency as a legal request.
REQ-030 SHALL use little-endian byte order: byte addr+i maps to data bits [8i+7:8i].
REQ-031 SHALL commit a legal store at the acceptance edge, writing only req_size bytes.
REQ-032 SHALL capture legal load data at the acceptance edge into a response register, zero-filling the upper bytes.
REQ-033 SHALL give a load immediately after a store to the same address the new data.

Reset
REQ-034 SHALL, while rst is high, force state IDLE, counter 0, resp_valid 0, resp_rdata 0 and resp_err 0.
REQ-035 SHALL drive req_ready=1 from the first rising edge after rst deasserts.
REQ-036 SHALL, on reset mid-operation, discard the pending response.
REQ-037 SHALL keep a store already committed at acceptance after reset; no rollback.
REQ-038 SHALL leave storage contents unaffected by rst, with storage initialised to all zeros at time 0.

Structure
REQ-039 SHALL place in shared package datamem_pkg:
- state enum {IDLE, WAIT, RESP}
- size constants SZ_B=1, SZ_H=2, SZ_W=4, SZ_D=8
- default MEM_BYTES
REQ-040 SHALL use one combinational sub-module, datamem_req_check (size/alignment/range → illegal flag), instantiated once.
REQ-041 SHALL hold storage as a byte array inferred in this module; no other sub-modules.

Verification
REQ-042 Reset, then store size 8, addr 0x10, data 0x0123456789ABCDEF; load size 8, addr 0x10 → rdata 0x0123456789ABCDEF, err 0, resp_valid exactly 2 cycles after each acceptance.
REQ-043 Load size 1, addr 0x13 after REQ-042 → rdata 0x0000000000000089; then load size 4, addr 0x14 → 0x0000000001234567.
REQ-044 Store size 2, addr 0x11 → resp_err 1; then load addr 0x10 → memory unchanged. Store size 3, addr 0x10 → resp_err 1, rdata 0.
REQ-045 Load size 8, addr MEM_BYTES-8 → err 0; addr MEM_BYTES → err 1; addr 0xFFFFFFFFFFFFFFF8 → err 1 (no wrap).
REQ-046 Hold resp_ready low 5 cycles in RESP → outputs stable, req_ready 0 throughout; then raise resp_ready → IDLE next cycle.
REQ-047 Assert rst during WAIT of a store to 0x20 → resp_valid 0 immediately; after reset, load addr 0x20 returns the stored data.

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared types and constants for the data memory responder.
// States, transfer sizes and the default storage size.
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  localparam int MEM_BYTES_DEF = 1024;

endpackage

// File: rtl/datamem_req_check.sv
// Request legality check: size, natural alignment and range.
// Range test uses a 65-bit sum so addresses near 2^64 cannot wrap.
module datamem_req_check
  import datamem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic [63:0] addr,
  input  logic [3:0]  size,
  output logic        illegal
);

  logic        size_ok;
  logic        misalign;
  logic        overrun;
  logic [64:0] end_addr;

  always_comb begin
    size_ok = 1'b0;
    unique case (1'b1)
      size == SZ_B: size_ok = 1'b1;
      size == SZ_H: size_ok = 1'b1;
      size == SZ_W: size_ok = 1'b1;
      size == SZ_D: size_ok = 1'b1;
      default:      size_ok = 1'b0;
    endcase
    misalign = (addr[3:0] & (size - 4'd1)) != 4'd0;
    end_addr = {1'b0, addr} + {61'd0, size};
    overrun  = end_addr > 65'(MEM_BYTES);
    illegal  = !size_ok || misalign || overrun;
  end

endmodule

// File: rtl/datamem_responder.sv
// Single-outstanding data memory responder with fixed latency.
// Stores commit and loads read at the acceptance edge.
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(MEM_BYTES);

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nx;
  logic          illegal;
  logic          accept;
  logic [AW-1:0] idx;
  logic [63:0]   ld;
  logic [7:0]    mem [MEM_BYTES];

  datamem_req_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .addr   (req_addr),
    .size   (req_size),
    .illegal(illegal)
  );

  assign req_ready  = (state == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign idx        = req_addr[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = WAIT;
          cnt_nx   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
        else cnt_nx = cnt - 4'd1;
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bytes beyond req_size read as zero, giving zero-extension.
  always_comb begin
    ld = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < req_size)
        ld[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (accept && req_write && !illegal) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < req_size)
          mem[idx + AW'(i)] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_err   <= illegal;
      resp_rdata <= (!illegal && !req_write) ? ld : '0;
    end else if (resp_valid && resp_ready) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
// Self-checking bench for datamem_responder.
// Byte-array reference model; directed plus random transactions.
module tb_datamem_responder;

  localparam int MEMB = 1024;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [MEMB];

  datamem_responder #(
    .MEM_BYTES(MEMB),
    .LATENCY  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model(input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic [3:0] s,
                       output logic [63:0] rd, output logic e);
    logic ok;
    ok = (s == 1) || (s == 2) || (s == 4) || (s == 8);
    if (ok) ok = (a % 64'(s)) == 0;
    if (ok) ok = a <= 64'(MEMB) - 64'(s);
    e  = !ok;
    rd = '0;
    if (ok) begin
      for (int i = 0; i < int'(s); i++) begin
        if (w) mm[int'(a) + i] = d[8*i +: 8];
        else rd[8*i +: 8] = mm[int'(a) + i];
      end
    end
  endtask

  task automatic junk_req();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = {$urandom, $urandom} & 64'h3F;
    req_wdata = {$urandom, $urandom};
    req_size  = 4'd8;
  endtask

  // Drives one transaction; returns response and observed latency.
  task automatic xact(input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [3:0] s,
                      input int hold,
                      output logic [63:0] rd, output logic e,
                      output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_size  = s;
    @(posedge clk); #1;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      junk_req();
      resp_ready = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    resp_ready = 1'b0;
    junk_req();
    rd = resp_rdata;
    e  = resp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_size   = 4'd1;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0
        || resp_rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_out: valid=%b err=%b rdata=%h want 0 0 0",
               resp_valid, resp_err, resp_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    logic [63:0] rd, xr;
    logic        e, xe;
    int          lat;
    model(1, 64'h10, 64'h0123456789ABCDEF, 8, xr, xe);
    xact(1, 64'h10, 64'h0123456789ABCDEF, 8, 0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 64'd0 || lat != LAT) begin
      errors++;
      $display("FAIL store8: err=%b rd=%h lat=%0d want 0 0 %0d",
               e, rd, lat, LAT);
    end
    model(0, 64'h10, 0, 8, xr, xe);
    xact(0, 64'h10, 64'd0, 8, 0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 64'h0123456789ABCDEF || lat != LAT) begin
      errors++;
      $display("FAIL load8: err=%b rd=%h lat=%0d want 0 %h %0d",
               e, rd, lat, 64'h0123456789ABCDEF, LAT);
    end
    xact(0, 64'h13, 64'd0, 1, 1, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 64'h89) begin
      errors++;
      $display("FAIL load1: err=%b rd=%h want 0 89", e, rd);
    end
    xact(0, 64'h14, 64'd0, 4, 0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 64'h01234567) begin
      errors++;
      $display("FAIL load4: err=%b rd=%h want 0 01234567", e, rd);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd, xr;
    logic        e, xe;
    int          lat;
    model(1, 64'h11, 64'hFFFF, 2, xr, xe);
    xact(1, 64'h11, 64'hFFFF, 2, 0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 64'd0 || lat != LAT) begin
      errors++;
      $display("FAIL misalign: err=%b rd=%h lat=%0d want 1 0 %0d",
               e, rd, lat, LAT);
    end
    xact(0, 64'h10, 64'd0, 8, 0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL unchanged: err=%b rd=%h want 0 0123456789abcdef",
               e, rd);
    end
    xact(1, 64'h10, 64'hAAAA_AAAA, 3, 0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 64'd0 || lat != LAT) begin
      errors++;
      $display("FAIL size3: err=%b rd=%h lat=%0d want 1 0 %0d",
               e, rd, lat, LAT);
    end
  endtask

  task automatic test_range();
    logic [63:0] rd, xr;
    logic        e, xe;
    int          lat;
    model(0, 64'(MEMB - 8), 0, 8, xr, xe);
    xact(0, 64'(MEMB - 8), 64'd0, 8, 0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== xr) begin
      errors++;
      $display("FAIL top_ok: err=%b rd=%h want 0 %h", e, rd, xr);
    end
    xact(0, 64'(MEMB), 64'd0, 8, 0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 64'd0) begin
      errors++;
      $display("FAIL past_end: err=%b rd=%h want 1 0", e, rd);
    end
    xact(0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 8, 0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 64'd0 || lat != LAT) begin
      errors++;
      $display("FAIL wrap: err=%b rd=%h lat=%0d want 1 0 %0d",
               e, rd, lat, LAT);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd0;
    logic        e0;
    int          lat;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h10;
    req_size  = 4'd8;
    @(posedge clk); #1;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      junk_req();
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL bp_lat: got %0d want %0d", lat, LAT);
    end
    rd0 = resp_rdata;
    e0  = resp_err;
    for (int c = 0; c < 5; c++) begin
      junk_req();
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0
          || resp_rdata !== 64'h0123456789ABCDEF
          || resp_rdata !== rd0 || resp_err !== e0) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b rdy=%b rd=%h err=%b", c,
                 resp_valid, req_ready, resp_rdata, resp_err);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: v=%b rdy=%b want 0 1",
               resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd, xr;
    logic        e, xe;
    int          lat;
    logic [63:0] d;
    d = {$urandom, $urandom};
    model(1, 64'h20, d, 8, xr, xe);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = d;
    req_size  = 4'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: v=%b rdy=%b want 0 0",
               resp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: rdy=%b v=%b want 1 0",
               req_ready, resp_valid);
    end
    model(0, 64'h20, 0, 8, xr, xe);
    xact(0, 64'h20, 64'd0, 8, 0, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== xr || rd !== d) begin
      errors++;
      $display("FAIL rst_keep: err=%b rd=%h want 0 %h", e, rd, d);
    end
  endtask

  task automatic test_random();
    logic [3:0]  sizes [13] = '{1, 2, 4, 8, 1, 2, 4, 8, 0, 3, 5, 9, 15};
    logic [63:0] rd, xr, a, d;
    logic        e, xe, w;
    logic [3:0]  s;
    int          lat, r;
    for (int k = 0; k < 150; k++) begin
      w = 1'($urandom);
      s = sizes[$urandom_range(0, 12)];
      d = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      if (r < 7)       a = 64'($urandom_range(0, 63));
      else if (r == 7) a = 64'(MEMB - $urandom_range(0, 16));
      else if (r == 8) a = {$urandom, $urandom};
      else             a = 64'hFFFF_FFFF_FFFF_FFF0
                           + 64'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1 && s != 0)
        a = a - (a % 64'(s));
      model(w, a, d, s, xr, xe);
      xact(w, a, d, s, $urandom_range(0, 3), rd, e, lat);
      checks++;
      if (e !== xe || rd !== xr || lat != LAT) begin
        errors++;
        $display("FAIL rand%0d: w=%b a=%h s=%0d err=%b rd=%h lat=%0d want %b %h %0d",
                 k, w, a, s, e, rd, lat, xe, xr, LAT);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) mm[i] = 8'h00;
    test_reset();
    test_basic();
    test_errors();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
